// File: rtl/remap_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : remap_packer_if
// Description : Sample-in / packed-word-out valid/ready bus of remap_packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface remap_packer_if #(
  parameter int M2_W   = 15,
  parameter int PACK_N = 4
);
  logic                     in_valid;
  logic [M2_W-1:0]          in_data;
  logic                     in_last;
  logic                     in_ready;
  logic                     out_valid;
  logic [M2_W*PACK_N-1:0]   out_data;
  logic [PACK_N-1:0]        out_mask;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last
  );
endinterface
`default_nettype wire

// File: rtl/remap_packer.sv
`default_nettype none
// ============================================================================
// Module      : remap_packer
// Description : Packs PACK_N remapped samples per output word, flushes partial
//               words on frame end, counts frames and flags bad frame lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module remap_packer #(
  parameter int M2_W      = 15,
  parameter int PACK_N    = 4,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  remap_packer_if.slave     bus,
  input  wire logic         err_clr,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_err
);

  localparam int                IDX_W       = $clog2(PACK_N);
  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(PACK_N - 1);
  localparam logic [CNT_W-1:0]  c_frame_len = CNT_W'(FRAME_LEN);

  logic [M2_W*PACK_N-1:0] r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_valid;
  logic [M2_W*PACK_N-1:0] r_out_data;
  logic [PACK_N-1:0]      r_out_mask;
  logic                   r_out_last;
  logic [CNT_W-1:0]       r_frame_cnt;
  logic                   r_frame_err;

  logic                   w_last_slot;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_complete;
  logic [M2_W*PACK_N-1:0] w_word;
  logic [PACK_N-1:0]      w_mask;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_err_set;

  assign w_last_slot = (r_idx == c_last_idx);
  assign bus.in_ready = !r_out_valid | bus.out_ready | (!w_last_slot & !bus.in_last);
  assign w_in_fire   = bus.in_valid & bus.in_ready;
  assign w_out_fire  = r_out_valid & bus.out_ready;
  assign w_complete  = w_in_fire & (w_last_slot | bus.in_last);

  // Accumulator view including the sample being accepted; slots above idx read as 0.
  for (genvar k = 0; k < PACK_N; k++) begin : g_slot
    assign w_mask[k] = (IDX_W'(k) <= r_idx);
    assign w_word[k*M2_W +: M2_W] = (IDX_W'(k) == r_idx) ? bus.in_data :
                                    (w_mask[k] ? r_acc[k*M2_W +: M2_W] : '0);
  end

  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_err_set  = w_in_fire &
                      ((bus.in_last  & (w_cnt_next != c_frame_len)) |
                       (!bus.in_last & (w_cnt_next == c_frame_len)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_complete) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_in_fire) begin
      r_acc <= w_word;
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_mask  <= w_mask;
      r_out_last  <= bus.in_last;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= bus.in_last ? '0 : w_cnt_next;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_err_set) begin
      r_frame_err <= 1'b1;
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_out_fire & r_out_last) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_mask  = r_out_mask;
  assign bus.out_last  = r_out_last;
  assign frame_cnt     = r_frame_cnt;
  assign frame_err     = r_frame_err;

endmodule
`default_nettype wire
